// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates the single register-file write port between the
// pipeline write-back stage and a small FIFO of long-latency results
// (multiply/divide, load-miss return).
//
// Optional feature macro: WB_ARB_STARVE_EN
//   defined     -> a wait counter forces STALL_REQ once a live queued result
//                  has been denied the port MAX_WAIT times in a row.
//   not defined -> STALL_REQ is asserted only while the FIFO is full.
module wb_port_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         WB_RegWrite,
  input  logic [4:0]                   WB_RD,
  input  logic [31:0]                  WB_WDATA,
  input  logic                         LL_VALID,
  input  logic [4:0]                   LL_RD,
  input  logic [31:0]                  LL_DATA,
  output logic                         LL_READY,
  output logic                         RF_WE,
  output logic [4:0]                   RF_WA,
  output logic [31:0]                  RF_WD,
  output logic                         STALL_REQ,
  output logic [$clog2(DEPTH+1)-1:0]   LL_COUNT
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("wb_port_arbiter: DEPTH must be a power of two and at least 2");
  end
  if (MAX_WAIT < 1) begin : g_wait_chk
    $error("wb_port_arbiter: MAX_WAIT must be at least 1");
  end

  // FIFO storage: each entry is {live, rd, data}.
  logic [DEPTH-1:0] r_live;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_wb_wr;
  logic w_head_live;
  logic w_push;
  logic w_push_live;
  logic w_pop;
  logic w_live_pop;
  logic w_starve;

  // Queue status and per-cycle grant decisions.
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    w_wb_wr     = WB_RegWrite && (WB_RD != 5'd0);
    w_head_live = !w_empty && r_live[r_rptr];
    // LL_RD==0 transfers are accepted (handshake completes) but never stored.
    w_push      = LL_VALID && !w_full && (LL_RD != 5'd0);
    // A same-cycle pipeline write to the same register is the younger write.
    w_push_live = !(w_wb_wr && (LL_RD == WB_RD));
    // Dead heads drain unconditionally; a live head pops only when granted.
    w_pop       = !w_empty && (!r_live[r_rptr] || !w_wb_wr);
    w_live_pop  = w_pop && w_head_live;
  end

  // FIFO entry storage, kill marking and push.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_live <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Kill marks are applied to every slot; stale slots are harmless because
      // they are rewritten with a fresh live bit on their next push.
      if (w_wb_wr) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_rd[i] == WB_RD) begin
            r_live[i] <= 1'b0;
          end
        end
      end
      if (w_push) begin
        r_live[r_wptr] <= w_push_live;
        r_rd[r_wptr]   <= LL_RD;
        r_data[r_wptr] <= LL_DATA;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Registered write port: pipeline first, then a live queued head.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RF_WE <= 1'b0;
      RF_WA <= '0;
      RF_WD <= '0;
    end else if (w_wb_wr) begin
      RF_WE <= 1'b1;
      RF_WA <= WB_RD;
      RF_WD <= WB_WDATA;
    end else if (w_head_live) begin
      RF_WE <= 1'b1;
      RF_WA <= r_rd[r_rptr];
      RF_WD <= r_data[r_rptr];
    end else begin
      RF_WE <= 1'b0;
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] r_wait;
  logic          r_starve;

  // Starvation tracking: count consecutive denials of a live head.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wait   <= '0;
      r_starve <= 1'b0;
    end else begin
      if (w_empty || w_live_pop) begin
        r_wait <= '0;
      end else if (w_head_live && w_wb_wr && (r_wait != WW'(MAX_WAIT))) begin
        r_wait <= r_wait + WW'(1);
      end
      // The flag sets on the same edge the counter lands on MAX_WAIT.
      if (w_live_pop) begin
        r_starve <= 1'b0;
      end else if (w_head_live && w_wb_wr && (r_wait >= WW'(MAX_WAIT - 1))) begin
        r_starve <= 1'b1;
      end
    end
  end

  assign w_starve = r_starve;
`else
  assign w_starve = 1'b0;
`endif

  // Handshake and status outputs, combinational from registered state.
  always_comb begin
    LL_READY  = !w_full;
    STALL_REQ = w_full || w_starve;
    LL_COUNT  = r_count;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// each register-file write; a monitor compares them as the DUT issues writes.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned CW       = $clog2(DEPTH+1);

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          WB_RegWrite = 1'b0;
  logic [4:0]    WB_RD = '0;
  logic [31:0]   WB_WDATA = '0;
  logic          LL_VALID = 1'b0;
  logic [4:0]    LL_RD = '0;
  logic [31:0]   LL_DATA = '0;
  logic          LL_READY;
  logic          RF_WE;
  logic [4:0]    RF_WA;
  logic [31:0]   RF_WD;
  logic          STALL_REQ;
  logic [CW-1:0] LL_COUNT;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .WB_RegWrite(WB_RegWrite), .WB_RD(WB_RD), .WB_WDATA(WB_WDATA),
    .LL_VALID(LL_VALID), .LL_RD(LL_RD), .LL_DATA(LL_DATA), .LL_READY(LL_READY),
    .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD),
    .STALL_REQ(STALL_REQ), .LL_COUNT(LL_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        live;
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  typedef struct {
    bit [4:0]  wa;
    bit [31:0] wd;
  } wr_t;

  ent_t mq[$];     // model of the long-latency queue
  wr_t  exp_q[$];  // expected register-file writes, in issue order
  int   m_wait = 0;
  bit   m_flag = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, check status outputs, advance model.
  task automatic cyc(input bit wbwe, input bit [4:0] wbrd, input bit [31:0] wbd,
                     input bit llv, input bit [4:0] llrd, input bit [31:0] lld);
    bit   full, wb, head_live, pop, live_pop;
    ent_t e;
    wr_t  w;
    @(negedge CLK);
    WB_RegWrite = wbwe; WB_RD = wbrd; WB_WDATA = wbd;
    LL_VALID = llv; LL_RD = llrd; LL_DATA = lld;
    #1;
    full = (mq.size() == DEPTH);
    chk("LL_READY", 32'(LL_READY), 32'(!full));
    chk("LL_COUNT", 32'(LL_COUNT), 32'(mq.size()));
    chk("STALL_REQ", 32'(STALL_REQ), 32'(full || m_flag));

    wb        = wbwe && (wbrd != 5'd0);
    head_live = (mq.size() > 0) && mq[0].live;
    if (wb) begin
      w.wa = wbrd; w.wd = wbd; exp_q.push_back(w);
    end else if (head_live) begin
      w.wa = mq[0].rd; w.wd = mq[0].data; exp_q.push_back(w);
    end
    pop      = (mq.size() > 0) && !(head_live && wb);
    live_pop = pop && head_live;
`ifdef WB_ARB_STARVE_EN
    if (mq.size() == 0 || live_pop) m_wait = 0;
    else if (head_live && wb && m_wait < int'(MAX_WAIT)) m_wait++;
    if (live_pop) m_flag = 0;
    else if (m_wait >= int'(MAX_WAIT)) m_flag = 1;
`endif
    if (wb) begin
      foreach (mq[i]) if (mq[i].rd == wbrd) mq[i].live = 0;
    end
    if (pop) void'(mq.pop_front());
    if (llv && !full && llrd != 5'd0) begin
      e.live = !(wb && llrd == wbrd);
      e.rd   = llrd;
      e.data = lld;
      mq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    WB_RegWrite = 1'b0; LL_VALID = 1'b0;
    #1;
    chk("rst_RF_WE", 32'(RF_WE), 32'd0);
    chk("rst_LL_COUNT", 32'(LL_COUNT), 32'd0);
    chk("rst_LL_READY", 32'(LL_READY), 32'd1);
    chk("rst_STALL_REQ", 32'(STALL_REQ), 32'd0);
    chk("rst_pending", 32'(exp_q.size()), 32'd0);
    mq.delete();
    exp_q.delete();
    m_wait = 0;
    m_flag = 0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Monitor: every issued write must match the next expected write.
  initial begin : monitor
    wr_t w;
    forever begin
      @(posedge CLK);
      #1;
      if (!RESET && RF_WE) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got RF_WE=1 WA=%0d WD=0x%0h expected no write at %0t",
                   RF_WA, RF_WD, $time);
        end else begin
          w = exp_q.pop_front();
          chk("RF_WA", 32'(RF_WA), 32'(w.wa));
          chk("RF_WD", RF_WD, w.wd);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int n;
    #2;
    chk("rst_RF_WA", 32'(RF_WA), 32'd0);
    chk("rst_RF_WD", RF_WD, 32'd0);
    do_reset();

    // Single live push is written on the next cycle.
    cyc(0, 5'd0, 32'd0, 1, 5'd5, 32'hA5A5_A5A5);
    idle(3);

    // Queued rd 3 is killed by a younger pipeline write; rd 4 survives.
    cyc(1, 5'd7, 32'h70, 1, 5'd3, 32'h33);
    cyc(1, 5'd7, 32'h71, 1, 5'd4, 32'h44);
    cyc(1, 5'd3, 32'h11, 0, 5'd0, 32'd0);
    idle(4);

    // Fill while the pipeline holds the port, one rejected extra, then drain.
    for (int i = 0; i < int'(DEPTH); i++)
      cyc(1, 5'd7, 32'h700 + 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i));
    cyc(1, 5'd7, 32'h7FF, 1, 5'd20, 32'hDEAD);
    idle(int'(DEPTH) + 2);

    // Same-cycle push and pipeline write to the same register.
    cyc(1, 5'd6, 32'h66, 1, 5'd6, 32'hBAD6);
    idle(2);

    // Writes to $0 from either source never happen.
    cyc(1, 5'd0, 32'hBAD0, 0, 5'd0, 32'd0);
    cyc(0, 5'd0, 32'd0, 1, 5'd0, 32'hBAD1);
    idle(2);

`ifdef WB_ARB_STARVE_EN
    // Live entry denied MAX_WAIT times forces a stall, released by its write.
    cyc(1, 5'd9, 32'h90, 1, 5'd2, 32'h22);
    for (int i = 0; i < int'(MAX_WAIT) + 2; i++)
      cyc(1, 5'd9, 32'h91 + 32'(i), 0, 5'd0, 32'd0);
    idle(3);
`endif

    // Reset with entries queued flushes them without any write.
    for (int i = 0; i < 3; i++)
      cyc(1, 5'd7, 32'h7A0 + 32'(i), 1, 5'(12 + i), 32'hC00 + 32'(i));
    do_reset();
    idle(4);

    // Randomized traffic with collisions on a small register range.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      cyc(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    // Drain with a bounded budget.
    n = 0;
    while (mq.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    chk("drain_queue", 32'(mq.size()), 32'd0);
    idle(2);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
